// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a bin2bcd_seq converter and its client.
// The client drives the operand and start request; the converter returns status and the packed BCD result.
interface bin2bcd_seq_if #(
   parameter int BIN_WIDTH = 14
);
   logic [BIN_WIDTH-1:0] BIN_IN;
   logic                 START;
   logic                 BUSY;
   logic                 DONE;
   logic [15:0]          BCD_OUT;
   logic                 OVF;

   modport master (
      output BIN_IN, START,
      input  BUSY, DONE, BCD_OUT, OVF
   );

   modport slave (
      input  BIN_IN, START,
      output BUSY, DONE, BCD_OUT, OVF
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Inputs above 9999 saturate to 9999 and flag OVF; results are held for the seven-segment decoder.
//
// state  | meaning
// IDLE   | waiting for START; BCD_OUT/OVF hold the last result
// SHIFT  | one correct-and-shift step per cycle, cnt steps remaining
// FINISH | publish scratch to BCD_OUT, pulse DONE, return to IDLE
module bin2bcd_seq #(
   parameter int BIN_WIDTH = 14
) (
   input  logic          CLK,
   input  logic          RESET_N,
   bin2bcd_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t               state, state_nx;
   logic [4:0]           cnt, cnt_nx;
   logic [15:0]          scratch, scratch_nx;
   logic [BIN_WIDTH-1:0] operand, operand_nx;
   logic                 ovf_pend, ovf_pend_nx;
   logic [15:0]          bcd_q, bcd_nx;
   logic                 ovf_q, ovf_nx;
   logic                 done_q, done_nx;
   logic                 busy_q, busy_nx;
   logic [15:0]          corr;
   logic [15:0]          bin_ext;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         cnt      <= '0;
         scratch  <= '0;
         operand  <= '0;
         ovf_pend <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         scratch  <= scratch_nx;
         operand  <= operand_nx;
         ovf_pend <= ovf_pend_nx;
         bcd_q    <= bcd_nx;
         ovf_q    <= ovf_nx;
         done_q   <= done_nx;
         busy_q   <= busy_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      scratch_nx  = scratch;
      operand_nx  = operand;
      ovf_pend_nx = ovf_pend;
      bcd_nx      = bcd_q;
      ovf_nx      = ovf_q;
      done_nx     = 1'b0;
      bin_ext     = 16'(bus.BIN_IN);

      // Add-3 correction on every digit in parallel; operand <= 9999 keeps each digit from wrapping.
      corr = scratch;
      for (int i = 0; i < 4; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            corr[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end

      case (state)
         IDLE: begin
            if (bus.START) begin
               cnt_nx     = 5'(BIN_WIDTH);
               scratch_nx = '0;
               state_nx   = SHIFT;
               if (bin_ext > 16'd9999) begin
                  operand_nx  = BIN_WIDTH'(16'd9999);
                  ovf_pend_nx = 1'b1;
               end else begin
                  operand_nx  = bus.BIN_IN;
                  ovf_pend_nx = 1'b0;
               end
            end
         end
         SHIFT: begin
            scratch_nx = {corr[14:0], operand[BIN_WIDTH-1]};
            operand_nx = operand << 1;
            cnt_nx     = cnt - 5'd1;
            if (cnt == 5'd1) begin
               state_nx = FINISH;
            end
         end
         FINISH: begin
            bcd_nx   = scratch;
            ovf_nx   = ovf_pend;
            done_nx  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx != IDLE);
   end

   assign bus.BUSY    = busy_q;
   assign bus.DONE    = done_q;
   assign bus.BCD_OUT = bcd_q;
   assign bus.OVF     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, saturation, ignored requests, back-to-back and async reset.
module tb_bin2bcd_seq;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   logic [15:0] last_bcd;
   logic        last_ovf;

   bin2bcd_seq_if #(.BIN_WIDTH(14)) bus ();

   bin2bcd_seq #(.BIN_WIDTH(14)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One conversion with a single-cycle START; optionally disturbs BIN_IN/START while busy.
   task automatic conv(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf,
                       input bit disturb, input string tag);
      int k;
      int busy_cnt;
      int hold_bad;
      int extra_done;
      bus.BIN_IN = v;
      bus.START  = 1'b1;
      step();
      bus.START  = 1'b0;
      k = 0;
      busy_cnt = 0;
      hold_bad = 0;
      while (!bus.DONE && k < 40) begin
         if (bus.BUSY) busy_cnt++;
         if (bus.BCD_OUT !== last_bcd || bus.OVF !== last_ovf) hold_bad++;
         if (disturb && (k == 3 || k == 10)) begin
            bus.START  = 1'b1;
            bus.BIN_IN = 14'd7;
         end else begin
            bus.START  = 1'b0;
         end
         step();
         k++;
      end
      bus.START = 1'b0;
      check({tag, "_latency"}, k, 15);
      check({tag, "_busy_cycles"}, busy_cnt, 15);
      check({tag, "_hold"}, hold_bad, 0);
      check({tag, "_bcd"}, bus.BCD_OUT, exp_bcd);
      check({tag, "_ovf"}, bus.OVF, exp_ovf);
      check({tag, "_busy_in_done"}, bus.BUSY, 1'b0);
      last_bcd = exp_bcd;
      last_ovf = exp_ovf;
      extra_done = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.DONE) extra_done++;
      end
      check({tag, "_single_done"}, extra_done, 0);
   endtask

   initial begin
      int k;
      int low;
      int dones;
      n_checks   = 0;
      n_pass     = 0;
      last_bcd   = 16'h0000;
      last_ovf   = 1'b0;
      rst_n      = 1'b0;
      bus.START  = 1'b0;
      bus.BIN_IN = '0;
      #2;
      check("rst_busy", bus.BUSY, 1'b0);
      check("rst_done", bus.DONE, 1'b0);
      check("rst_bcd", bus.BCD_OUT, 16'h0000);
      check("rst_ovf", bus.OVF, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      step();

      conv(14'd1234,  16'h1234, 1'b0, 1'b0, "c1234");
      conv(14'd0,     16'h0000, 1'b0, 1'b0, "c0");
      conv(14'd9999,  16'h9999, 1'b0, 1'b0, "c9999");
      conv(14'd10,    16'h0010, 1'b0, 1'b0, "c10");
      conv(14'd12000, 16'h9999, 1'b1, 1'b0, "c12000");
      conv(14'd5,     16'h0005, 1'b0, 1'b0, "c5");
      conv(14'd4321,  16'h4321, 1'b0, 1'b1, "c4321_ignore");

      // START held high: a new conversion is accepted in every DONE cycle.
      bus.BIN_IN = 14'd5678;
      bus.START  = 1'b1;
      step();
      k = 0;
      while (!bus.DONE && k < 40) begin
         step();
         k++;
      end
      check("cont_first_latency", k, 15);
      check("cont_first_bcd", bus.BCD_OUT, 16'h5678);
      for (int r = 0; r < 2; r++) begin
         k = 0;
         low = 0;
         do begin
            step();
            k++;
            if (!bus.BUSY) low++;
         end while (!bus.DONE && k < 40);
         check("cont_period", k, 16);
         check("cont_busy_low", low, 1);
         check("cont_bcd", bus.BCD_OUT, 16'h5678);
      end
      bus.START = 1'b0;
      step();
      check("cont_stop_busy", bus.BUSY, 1'b0);
      last_bcd = 16'h5678;
      last_ovf = 1'b0;
      step();

      conv(14'd1111, 16'h1111, 1'b0, 1'b0, "c1111");

      // Abort an 8888 conversion with a mid-cycle asynchronous reset.
      bus.BIN_IN = 14'd8888;
      bus.START  = 1'b1;
      step();
      bus.START  = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("abort_busy_before", bus.BUSY, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_busy", bus.BUSY, 1'b0);
      check("abort_bcd", bus.BCD_OUT, 16'h0000);
      check("abort_ovf", bus.OVF, 1'b0);
      check("abort_done", bus.DONE, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.DONE) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_bcd_held", bus.BCD_OUT, 16'h0000);
      last_bcd = 16'h0000;
      last_ovf = 1'b0;

      conv(14'd42, 16'h0042, 1'b0, 1'b0, "c42");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
